// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: registered Fetch redirect, Decode/Execute flush window and saturating taken/not-taken counters
module branch_redirect_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DRAIN_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BranchE,
  input  logic              CondExE,
  input  logic [ADDR_W-1:0] BranchTargetE,
  input  logic              StallE,
  input  logic              FetchReady,
  input  logic              CntClr,
  output logic              PCSrcF,
  output logic [ADDR_W-1:0] PCTargetF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              Busy,
  output logic [CNT_W-1:0]  TakenCnt,
  output logic [CNT_W-1:0]  NotTakenCnt
);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [3:0] drain_q, drain_d;
  logic [CNT_W-1:0] tk_q, tk_d, nt_q, nt_d;
  logic acc;
  always_comb begin
    acc = BranchE & ~StallE & (state_q == IDLE);
    state_d = state_q == IDLE ? (acc & CondExE ? REDIRECT : IDLE) :
              state_q == REDIRECT ? (!FetchReady ? REDIRECT : (DRAIN_CYC == 0 ? IDLE : DRAIN)) :
              (drain_q <= 4'd1 ? IDLE : DRAIN);
    drain_d = (state_q == REDIRECT && FetchReady) ? 4'(DRAIN_CYC) :
              state_q == DRAIN ? drain_q - 4'd1 : drain_q;
    tgt_d = acc & CondExE ? BranchTargetE : tgt_q;
    tk_d = CntClr ? '0 : (acc & CondExE & ~&tk_q) ? tk_q + CNT_W'(1) : tk_q;
    nt_d = CntClr ? '0 : (acc & ~CondExE & ~&nt_q) ? nt_q + CNT_W'(1) : nt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      drain_q <= '0;
      tk_q    <= '0;
      nt_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      drain_q <= drain_d;
      tk_q    <= tk_d;
      nt_q    <= nt_d;
    end
  end
  assign PCSrcF      = state_q == REDIRECT;
  assign FlushE      = state_q == REDIRECT;
  assign FlushD      = state_q != IDLE;
  assign Busy        = state_q != IDLE;
  assign PCTargetF   = tgt_q;
  assign TakenCnt    = tk_q;
  assign NotTakenCnt = nt_q;
endmodule
